apb_master_arb: RTL
===================

// Module: apb_master_arb
// PURPOSE
//  Two-requester APB master: arbitrates between requester 0 and requester 1 (e.g. CPU
//  shim and UART TX/RX data mover) and sequences the shared APB SETUP/ACCESS phases
//  toward the UART APB slave. Adds a pready timeout so a hung slave cannot stall the bus.
// PARAMETERS
//  ADDR_W   12  APB address width
//  DATA_W   32  APB data width
//  TIMEOUT  16  max ACCESS cycles waiting for pready before abort (>=2)
// PORTS
//  sys_clk      in   1       single clock; all logic on rising edge
//  sys_rst      in   1       asynchronous, active-high reset
//  req0_valid   in   1       requester 0 transfer request; hold until req0_done
//  req0_write   in   1       1=write, 0=read
//  req0_addr    in   ADDR_W  transfer address
//  req0_wdata   in   DATA_W  write data
//  req0_done    out  1       one-cycle completion pulse
//  req0_err     out  1       valid with req0_done: 1=timeout abort
//  req0_rdata   out  DATA_W  read data, valid with req0_done
//  req1_*       -    -       identical set for requester 1
//  psel         out  1       APB select
//  penable      out  1       APB enable (ACCESS phase)
//  pwrite       out  1       APB direction
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, timeout count=0, last_grant=1 (req0 wins first).
//  - FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE; all outputs registered.
//  - IDLE: if any reqN_valid, grant by round-robin (the requester not granted last wins
//    when both valid; sole requester wins). Latch write/addr/wdata into APB regs, psel=1,
//    penable=0, go SETUP. No request: stay IDLE, psel=penable=0.
//  - SETUP (1 cycle): penable<=1, go ACCESS. paddr/pwdata/pwrite stable SETUP..ACCESS.
//  - ACCESS: sample pready each edge. pready=1: capture prdata (reads; 0 for writes),
//    psel=penable=0, go DONE. Else count; if count reaches TIMEOUT-1 without pready:
//    psel=penable=0, set err, rdata=0, go DONE.
//  - DONE (1 cycle): granted reqN_done=1 with reqN_err/reqN_rdata; other requester's
//    done=0. Update last_grant; go IDLE. Count cleared.
//  - Min latency valid-in-IDLE to done: 4 cycles with zero-wait slave; the UART slave
//    (pready one cycle after penable) gives 5. Minimum one IDLE cycle between transfers.
//  - reqN_rdata/err hold last value until next done for that requester.
//  - valid dropped mid-transfer: ignored, transfer completes and done still pulses.
//  - New valid from the non-granted requester while busy: waits; it wins next IDLE.
//  - paddr/pwdata/pwrite keep last value in IDLE (only psel/penable return to 0).
//  - sys_rst asserted mid-transfer: immediate return to reset state, no done pulse.
// TESTING
//  1. req0 write addr=0x004 data=0xA5 vs UART slave -> psel 1 cycle before penable,
//     penable held until pready, req0_done one pulse, req0_err=0, 5-cycle latency.
//  2. req1 read addr=0x008, slave prdata=0x1234 on pready -> req1_rdata=0x1234 with
//     req1_done, req1_err=0.
//  3. req0 and req1 both valid continuously, 4 transfers -> grant order 0,1,0,1;
//     exactly one done per transfer; IDLE cycle between transfers.
//  4. pready tied 0, TIMEOUT=16 -> ACCESS lasts 16 cycles, then psel=penable=0,
//     req0_done=1 with req0_err=1, req0_rdata=0; next request proceeds normally.
//  5. sys_rst pulsed during ACCESS -> psel/penable/done drop to 0 asynchronously; after
//     release, pending req1 and req0 both valid -> req0 granted first.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: requester handshakes and the shared APB bus of the two-requester APB master.
interface apb_master_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_done;
    logic              req0_err;
    logic [DATA_W-1:0] req0_rdata;
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_done;
    logic              req1_err;
    logic [DATA_W-1:0] req1_rdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_err, req1_rdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_err, req1_rdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter for two requesters driving one APB master with pready timeout.
module apb_master_arb #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic sys_clk,
    input logic sys_rst,
    apb_master_arb_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic last, last_n, gnt, gnt_n, pick, any, expired;
    logic psel_n, penable_n, pwrite_n, ecap, ecap_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n, rcap, rcap_n;
    logic done0_n, done1_n, err0_n, err1_n;
    logic [DATA_W-1:0] rdata0_n, rdata1_n;
    assign any = bus.req0_valid | bus.req1_valid;
    // the requester not served last wins a tie; a sole requester always wins
    assign pick = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;
    assign expired = cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any ? SETUP : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = (bus.pready || expired) ? DONE : ACCESS;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        cnt_n     = cnt;
        last_n    = last;
        gnt_n     = gnt;
        psel_n    = bus.psel;
        penable_n = bus.penable;
        pwrite_n  = bus.pwrite;
        paddr_n   = bus.paddr;
        pwdata_n  = bus.pwdata;
        rcap_n    = rcap;
        ecap_n    = ecap;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        err0_n    = bus.req0_err;
        err1_n    = bus.req1_err;
        rdata0_n  = bus.req0_rdata;
        rdata1_n  = bus.req1_rdata;
        case (state)
            IDLE: if (any) begin
                gnt_n     = pick;
                pwrite_n  = pick ? bus.req1_write : bus.req0_write;
                paddr_n   = pick ? bus.req1_addr  : bus.req0_addr;
                pwdata_n  = pick ? bus.req1_wdata : bus.req0_wdata;
                psel_n    = 1'b1;
                penable_n = 1'b0;
            end
            SETUP: penable_n = 1'b1;
            ACCESS: begin
                cnt_n = cnt + 1'b1;
                if (bus.pready || expired) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    ecap_n    = ~bus.pready;
                    rcap_n    = (bus.pready && !bus.pwrite) ? bus.prdata : '0;
                end
            end
            default: begin
                cnt_n   = '0;
                last_n  = gnt;
                done0_n = ~gnt;
                done1_n = gnt;
                if (gnt) begin
                    err1_n   = ecap;
                    rdata1_n = rcap;
                end else begin
                    err0_n   = ecap;
                    rdata0_n = rcap;
                end
            end
        endcase
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt            <= '0;
            last           <= 1'b1;
            gnt            <= 1'b0;
            rcap           <= '0;
            ecap           <= 1'b0;
            bus.psel       <= 1'b0;
            bus.penable    <= 1'b0;
            bus.pwrite     <= 1'b0;
            bus.paddr      <= '0;
            bus.pwdata     <= '0;
            bus.req0_done  <= 1'b0;
            bus.req1_done  <= 1'b0;
            bus.req0_err   <= 1'b0;
            bus.req1_err   <= 1'b0;
            bus.req0_rdata <= '0;
            bus.req1_rdata <= '0;
        end else begin
            cnt            <= cnt_n;
            last           <= last_n;
            gnt            <= gnt_n;
            rcap           <= rcap_n;
            ecap           <= ecap_n;
            bus.psel       <= psel_n;
            bus.penable    <= penable_n;
            bus.pwrite     <= pwrite_n;
            bus.paddr      <= paddr_n;
            bus.pwdata     <= pwdata_n;
            bus.req0_done  <= done0_n;
            bus.req1_done  <= done1_n;
            bus.req0_err   <= err0_n;
            bus.req1_err   <= err1_n;
            bus.req0_rdata <= rdata0_n;
            bus.req1_rdata <= rdata1_n;
        end
    end
endmodule
